tmds_tx_sequencer: RTL and testbench

//  Sequences the three tmds_gen channel encoders (R,G,B) of the HDMI/DVI output.

---
 rtl/tmds_tx_pkg.sv | 39 +++
 rtl/video_timing_counter.sv | 78 +++++++
 rtl/tmds_tx_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_tmds_tx_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_tx_pkg.sv
// -----------------------------------------------------------------------------
// tmds_tx_pkg
//   Shared types and helpers for the TMDS transmit sequencer.
//   - seq_state_e : sequencer FSM states (IDLE, RUN, DRAIN)
//   - rgb_t       : packed {r,g,b} pixel, same layout as the 24-bit pixel bus
//   - CTRL_*      : fixed control symbols for the channels that carry no sync
//   - h_total() / v_total() : raster totals derived from the timing parameters
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package tmds_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Green and red encoders never carry sync; their control input is constant.
  localparam logic [1:0] CTRL_GREEN = 2'b00;
  localparam logic [1:0] CTRL_RED   = 2'b00;

  // Number of vertical bars in the built-in test pattern.
  localparam int NUM_BARS = 8;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// -----------------------------------------------------------------------------
// video_timing_counter
//   Horizontal/vertical raster counters plus the region flags derived from them.
//   Ordering per line/frame: active, front porch, sync, back porch.
//   Ports:
//     i_clk, i_rst     pixel clock, asynchronous active-high reset
//     i_run            advance counters; when low they are held at (0,0)
//     o_hcnt, o_vcnt   current raster position
//     o_active         position lies in the visible area
//     o_hsync          hcnt inside the horizontal sync window
//     o_vsync          vcnt inside the vertical sync window (whole lines)
//     o_last_cycle     last cycle of the frame (H_TOTAL-1, V_TOTAL-1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module video_timing_counter
  import tmds_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  output logic [HW-1:0] o_hcnt,
  output logic [VW-1:0] o_vcnt,
  output logic          o_active,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_last_cycle
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Region boundaries sized to the counters so every compare is width-matched.
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_EN = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_EN = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

  logic [HW-1:0] hcnt_reg;
  logic [VW-1:0] vcnt_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (!i_run) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == H_LAST) begin
      hcnt_reg <= '0;
      vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
    end else begin
      hcnt_reg <= hcnt_reg + 1'b1;
    end
  end

  assign o_hcnt       = hcnt_reg;
  assign o_vcnt       = vcnt_reg;
  assign o_active     = (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
  assign o_hsync      = (hcnt_reg >= H_SYNC_ST) && (hcnt_reg < H_SYNC_EN);
  assign o_vsync      = (vcnt_reg >= V_SYNC_ST) && (vcnt_reg < V_SYNC_EN);
  assign o_last_cycle = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

endmodule

// File: rtl/tmds_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tmds_tx_sequencer
//   Drives the three TMDS channel encoders: raster timing, blanking, sync
//   control symbols on blue, and pixel data pulled from upstream via req/valid.
//   Optional feature macro: TMDS_TX_TEST_PATTERN_EN (adds i_pattern_sel and an
//   8-bar colour test pattern).
//   Ports:
//     i_clk, i_rst          pixel clock, asynchronous active-high reset
//     i_enable              run request (takes effect at frame boundaries)
//     o_pix_req             pixel consumed this cycle if i_pix_valid
//     i_pix_valid/i_pix_rgb upstream pixel {R,G,B}
//     i_clr_underflow       clears the sticky underflow flag
//     i_pattern_sel         (macro only) select test pattern for active pixels
//     o_data_r/g/b          encoder data inputs
//     o_ctrl_b              blue control = {VSYNC,HSYNC}; o_ctrl_g/r constant 0
//     o_blanking            encoder blanking select
//     o_x/o_y               raster position matching the encoder outputs
//     o_frame_start         pulse with pixel (0,0) on the encoder outputs
//     o_underflow           sticky upstream underflow flag
//     o_busy                sequencer not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tmds_tx_sequencer
  import tmds_tx_pkg::*;
#(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter logic        SYNC_POL     = 1'b0,
  parameter logic [23:0] FALLBACK_RGB = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_pix_req,
  input  logic        i_pix_valid,
  input  logic [23:0] i_pix_rgb,
  input  logic        i_clr_underflow,
`ifdef TMDS_TX_TEST_PATTERN_EN
  input  logic        i_pattern_sel,
`endif
  output logic [7:0]  o_data_r,
  output logic [7:0]  o_data_g,
  output logic [7:0]  o_data_b,
  output logic [1:0]  o_ctrl_b,
  output logic [1:0]  o_ctrl_g,
  output logic [1:0]  o_ctrl_r,
  output logic        o_blanking,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic        o_busy
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [1:0] CTRL_IDLE_B = {~SYNC_POL, ~SYNC_POL};

  seq_state_e    state_reg;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          in_active;
  logic          in_hsync;
  logic          in_vsync;
  logic          last_cycle;
  logic          running;

  assign running = (state_reg != IDLE);

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (running),
    .o_hcnt       (hcnt),
    .o_vcnt       (vcnt),
    .o_active     (in_active),
    .o_hsync      (in_hsync),
    .o_vsync      (in_vsync),
    .o_last_cycle (last_cycle)
  );

  // ---------------------------------------------------------------------------
  // Pixel source: upstream stream, fallback colour, or optional test pattern.
  // ---------------------------------------------------------------------------
  logic use_pattern;
  rgb_t pattern_rgb;

`ifdef TMDS_TX_TEST_PATTERN_EN
  localparam int            BAR_WIDTH = H_ACTIVE / NUM_BARS;
  localparam logic [HW-1:0] BAR_DIV   = HW'(BAR_WIDTH);

  logic [HW-1:0] bar_idx;

  assign use_pattern = i_pattern_sel;
  // Only meaningful inside the active region, where the quotient is 0..7.
  assign bar_idx     = hcnt / BAR_DIV;

  // Channel gi (0=B, 1=G, 2=R) is fully lit when its bar-index bit is set.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar
    assign pattern_rgb[gi*8 +: 8] = {8{bar_idx[gi]}};
  end
`else
  assign use_pattern = 1'b0;
  assign pattern_rgb = '0;
`endif

  rgb_t active_rgb;
  logic underflow_now;

  always_comb begin
    active_rgb    = rgb_t'(i_pix_rgb);
    underflow_now = 1'b0;
    if (use_pattern) begin
      active_rgb = pattern_rgb;
    end else if (!i_pix_valid) begin
      // The raster never waits for upstream: substitute and flag.
      active_rgb    = rgb_t'(FALLBACK_RGB);
      underflow_now = running && in_active;
    end
  end

  // Request is combinational so the upstream sees it in the same cycle as the
  // counter position it belongs to; the data it returns is registered below.
  assign o_pix_req = running && in_active && !use_pattern;
  assign o_busy    = running;
  assign o_ctrl_g  = CTRL_GREEN;
  assign o_ctrl_r  = CTRL_RED;

  logic hsync_lvl;
  logic vsync_lvl;

  assign hsync_lvl = in_hsync ? SYNC_POL : ~SYNC_POL;
  assign vsync_lvl = in_vsync ? SYNC_POL : ~SYNC_POL;

  // ---------------------------------------------------------------------------
  // FSM and registered encoder-facing outputs (one cycle behind the counters).
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      o_data_r      <= '0;
      o_data_g      <= '0;
      o_data_b      <= '0;
      o_ctrl_b      <= CTRL_IDLE_B;
      o_blanking    <= 1'b1;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_enable) state_reg <= RUN;
        end
        RUN: begin
          // Dropping enable on the final cycle needs no drain frame.
          if (!i_enable) state_reg <= last_cycle ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (i_enable)        state_reg <= RUN;
          else if (last_cycle) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (!running) begin
        o_data_r      <= '0;
        o_data_g      <= '0;
        o_data_b      <= '0;
        o_ctrl_b      <= CTRL_IDLE_B;
        o_blanking    <= 1'b1;
        o_x           <= '0;
        o_y           <= '0;
        o_frame_start <= 1'b0;
      end else begin
        o_x           <= 10'(hcnt);
        o_y           <= 10'(vcnt);
        o_frame_start <= (hcnt == '0) && (vcnt == '0);
        o_ctrl_b      <= {vsync_lvl, hsync_lvl};
        if (in_active) begin
          o_data_r   <= active_rgb.r;
          o_data_g   <= active_rgb.g;
          o_data_b   <= active_rgb.b;
          o_blanking <= 1'b0;
        end else begin
          o_data_r   <= '0;
          o_data_g   <= '0;
          o_data_b   <= '0;
          o_blanking <= 1'b1;
        end
      end

      // A fresh underflow beats a simultaneous clear.
      if (underflow_now)        o_underflow <= 1'b1;
      else if (i_clr_underflow) o_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tmds_tx_sequencer
//   Directed bench on a shrunken raster (16+2+4+3 x 6+1+2+1 = 25 x 10) so whole
//   frames stay short. A behavioural raster model pushes the expected encoder
//   outputs each cycle; they are popped and compared after the clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tmds_tx_sequencer;

  localparam int          HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int          VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam logic [23:0] FB = 24'h0A0B0C;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pix_req;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        clr_uf;
  logic [7:0]  data_r, data_g, data_b;
  logic [1:0]  ctrl_b, ctrl_g, ctrl_r;
  logic        blanking;
  logic [9:0]  x, y;
  logic        frame_start;
  logic        underflow;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tmds_tx_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .FALLBACK_RGB(FB)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (en),
    .o_pix_req       (pix_req),
    .i_pix_valid     (pix_valid),
    .i_pix_rgb       (pix_rgb),
    .i_clr_underflow (clr_uf),
`ifdef TMDS_TX_TEST_PATTERN_EN
    .i_pattern_sel   (1'b0),
`endif
    .o_data_r        (data_r),
    .o_data_g        (data_g),
    .o_data_b        (data_b),
    .o_ctrl_b        (ctrl_b),
    .o_ctrl_g        (ctrl_g),
    .o_ctrl_r        (ctrl_r),
    .o_blanking      (blanking),
    .o_x             (x),
    .o_y             (y),
    .o_frame_start   (frame_start),
    .o_underflow     (underflow),
    .o_busy          (busy)
  );

  typedef struct {
    logic [23:0] data;
    logic        blank;
    logic [1:0]  ctrl_b;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        uf;
    logic        busy;
    logic        req;
  } exp_t;

  exp_t sb_q[$];

  // Model state: 0 idle, 1 run, 2 drain; position of the DUT counters.
  int   m_state;
  int   m_h;
  int   m_v;
  logic m_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_h     = 0;
    m_v     = 0;
    m_uf    = 1'b0;
    sb_q.delete();
  endtask

  // Predict the outputs after the coming edge from the current inputs.
  task automatic model_push();
    exp_t e;
    int   ns;
    logic last;
    logic act;
    act = (m_h < HA) && (m_v < VA);
    if (m_state == 0) begin
      e.data = 24'h0; e.blank = 1'b1; e.ctrl_b = 2'b11;
      e.x = 10'd0; e.y = 10'd0; e.fs = 1'b0;
    end else begin
      e.x  = 10'(m_h);
      e.y  = 10'(m_v);
      e.fs = (m_h == 0) && (m_v == 0);
      e.ctrl_b = {~(m_v >= VA + VF && m_v < VA + VF + VS),
                  ~(m_h >= HA + HF && m_h < HA + HF + HS)};
      if (act) begin
        e.blank = 1'b0;
        e.data  = pix_valid ? pix_rgb : FB;
      end else begin
        e.blank = 1'b1;
        e.data  = 24'h0;
      end
    end
    if (m_state != 0 && act && !pix_valid) m_uf = 1'b1;
    else if (clr_uf)                       m_uf = 1'b0;
    e.uf = m_uf;

    last = (m_h == HT - 1) && (m_v == VT - 1);
    ns   = m_state;
    case (m_state)
      0: if (en) ns = 1;
      1: if (!en) ns = last ? 0 : 2;
      default: if (en) ns = 1; else if (last) ns = 0;
    endcase
    if (m_state != 0) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    m_state = ns;
    e.busy  = (ns != 0);
    e.req   = (ns != 0) && (m_h < HA) && (m_v < VA);
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("data",     {8'h0, data_r, data_g, data_b}, {8'h0, e.data});
    chk("blanking", blanking,        e.blank);
    chk("ctrl_b",   ctrl_b,          e.ctrl_b);
    chk("ctrl_gr",  {ctrl_g, ctrl_r}, 4'b0000);
    chk("x",        x,               e.x);
    chk("y",        y,               e.y);
    chk("frame_st", frame_start,     e.fs);
    chk("underflow", underflow,      e.uf);
    chk("busy",     busy,            e.busy);
    chk("pix_req",  pix_req,         e.req);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic drive(input logic d_en, input logic d_valid, input logic [23:0] d_rgb,
                       input logic d_clr);
    en        = d_en;
    pix_valid = d_valid;
    pix_rgb   = d_rgb;
    clr_uf    = d_clr;
    model_push();
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_data"},  {8'h0, data_r, data_g, data_b}, 32'h0);
    chk({tag, "_blank"}, blanking,    1'b1);
    chk({tag, "_ctrlb"}, ctrl_b,      2'b11);
    chk({tag, "_xy"},    {x, y},      20'h0);
    chk({tag, "_fs"},    frame_start, 1'b0);
    chk({tag, "_uf"},    underflow,   1'b0);
    chk({tag, "_busy"},  busy,        1'b0);
    chk({tag, "_req"},   pix_req,     1'b0);
  endtask

  initial begin
    logic [23:0] rnd;
    logic        drop;
    int          start_cmp;

    rst = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_rgb = 24'h0; clr_uf = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk("reset");
    rst = 1'b0;
    $display("step 1: reset values checked, compared=%0d", compared);

    // Idle with enable low: nothing moves.
    start_cmp = compared;
    repeat (100) drive(1'b0, 1'b1, 24'h123456, 1'b0);
    $display("step 2: idle 100 cycles, compared=%0d", compared - start_cmp);

    // Two full frames with a constant colour, then one with random pixels.
    start_cmp = compared;
    repeat (2 * HT * VT + 1) drive(1'b1, 1'b1, 24'h123456, 1'b0);
    repeat (HT * VT) begin
      rnd = 24'($urandom);
      drive(1'b1, 1'b1, rnd, 1'b0);
    end
    $display("step 3: run frames constant+random, compared=%0d", compared - start_cmp);

    // Underflow: ignored in blanking, set in active, sticky, set beats clear,
    // then clear.
    start_cmp = compared;
    repeat (HT * VT) begin
      logic v;
      logic c;
      v = !((m_h == 20 && m_v == 1) || (m_h == 10 && m_v == 3) || (m_h == 5 && m_v == 4));
      c = (m_h == 5 && m_v == 4) || (m_h == 0 && m_v == 5);
      rnd = 24'($urandom);
      drive(1'b1, v, rnd, c);
    end
    $display("step 4: underflow set/sticky/clear, compared=%0d", compared - start_cmp);

    // Brief enable drop (drain then resume), then a real stop mid-frame.
    start_cmp = compared;
    repeat (HT * VT) drive(!(m_v == 1 && m_h < 10), 1'b1, 24'hC0FFEE, 1'b0);
    drop = 1'b0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (m_v == 2) drop = 1'b1;
      drive(!drop, 1'b1, 24'h55AA33, 1'b0);
      if (m_state == 0) break;
    end
    chk("stopped_idle", busy, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 24'h55AA33, 1'b0);
    $display("step 5: drain/resume and stop at frame end, compared=%0d", compared - start_cmp);

    // Restart and hit asynchronous reset in the middle of an active line.
    start_cmp = compared;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (m_h == 7 && m_v == 4 && m_state != 0) break;
      drive(1'b1, 1'b1, 24'h778899, 1'b0);
    end
    chk("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    reset_chk("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_chk("held_rst");
    rst = 1'b0;
    repeat (HT * 3) drive(1'b1, 1'b1, 24'h010203, 1'b0);
    $display("step 6: async reset mid-frame and restart, compared=%0d", compared - start_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
